// File: rtl/calc2_sched.sv
// ---------------------------------------------------------------------------
// calc2_sched -- issue scheduler for a two-unit calculator (adder + shifter)
//
// Four requester ports present a 4-bit command and a 2-bit tag. The
// scheduler keeps a per-port outstanding-tag bitmap. A request is eligible
// only when its (port, tag) pair is not already in flight. Eligible requests
// are steered by command class:
//    1, 2  -> adder channel    (round-robin, own pointer)
//    5, 6  -> shifter channel  (round-robin, own pointer)
//    other -> invalid channel  (fixed priority, lowest port first)
//    0     -> idle
// Grants are combinational with zero latency, and all three channels may
// fire in the same cycle. Responses retire through done_vld/done_tag. They
// clear bitmap bits, and a retire of a tag that is not in flight raises a
// sticky error.
//
// Ports
//    c_clk       in   1  clock, rising edge
//    reset       in   1  synchronous, active-high
//    req_cmd_in  in  16  port p command in bits [4p+3:4p] (p = 0..3)
//    req_tag_in  in   8  port p tag in bits [2p+1:2p]
//    req_ack     out  4  one-cycle accept pulse per port
//    add_*       out     adder issue: vld / cmd[4] / port[2] / tag[2]
//    shf_*       out     shifter issue: vld / cmd[4] / port[2] / tag[2]
//    inv_*       out     invalid-command issue: vld / port[2] / tag[2]
//    done_vld    in   4  per-port retire strobe
//    done_tag    in   8  per-port retired tag, same packing as req_tag_in
//    sched_err   out  1  sticky retire-without-outstanding error
// ---------------------------------------------------------------------------
module calc2_sched (
   input  logic        c_clk,
   input  logic        reset,
   input  logic [15:0] req_cmd_in,
   input  logic [7:0]  req_tag_in,
   output logic [3:0]  req_ack,
   output logic        add_vld,
   output logic [3:0]  add_cmd,
   output logic [1:0]  add_port,
   output logic [1:0]  add_tag,
   output logic        shf_vld,
   output logic [3:0]  shf_cmd,
   output logic [1:0]  shf_port,
   output logic [1:0]  shf_tag,
   output logic        inv_vld,
   output logic [1:0]  inv_port,
   output logic [1:0]  inv_tag,
   input  logic [3:0]  done_vld,
   input  logic [7:0]  done_tag,
   output logic        sched_err
);

   localparam logic [3:0] CMD_IDLE  = 4'd0;
   localparam logic [3:0] CMD_ADD_A = 4'd1;
   localparam logic [3:0] CMD_ADD_B = 4'd2;
   localparam logic [3:0] CMD_SHF_A = 4'd5;
   localparam logic [3:0] CMD_SHF_B = 4'd6;

   // ------------------------------------------------------------------------
   // Registered state
   // ------------------------------------------------------------------------
   logic [3:0][3:0] bitmap_q, bitmap_d;     // [port][tag] outstanding
   logic [1:0]      add_ptr_q, add_ptr_d;   // adder round-robin start port
   logic [1:0]      shf_ptr_q, shf_ptr_d;   // shifter round-robin start port
   logic            err_q, err_d;

   // ------------------------------------------------------------------------
   // Per-port views of the packed request and retire buses
   // ------------------------------------------------------------------------
   logic [3:0][3:0] port_cmd;
   logic [3:0][1:0] port_tag;
   logic [3:0][1:0] port_done_tag;

   assign port_cmd      = req_cmd_in;
   assign port_tag      = req_tag_in;
   assign port_done_tag = done_tag;

   // ------------------------------------------------------------------------
   // Round-robin pick: the first requesting port at or after ptr, wrapping.
   // The result is {found, port}. A ptr of 0 gives fixed lowest-first
   // priority, which the invalid channel reuses.
   // ------------------------------------------------------------------------
   function automatic logic [2:0] rr_pick(input logic [3:0] req,
                                          input logic [1:0] ptr);
      logic [2:0] pick;
      logic [1:0] cand;
      pick = 3'b000;
      cand = 2'd0;
      for (int k = 0; k < 4; k++) begin
         cand = ptr + 2'(k);
         if (!pick[2] && req[cand]) begin
            pick = {1'b1, cand};
         end
      end
      return pick;
   endfunction

   // ------------------------------------------------------------------------
   // Eligibility and class decode
   // ------------------------------------------------------------------------
   logic [3:0] elig;
   logic [3:0] add_req;
   logic [3:0] shf_req;
   logic [3:0] inv_req;

   always_comb begin : decode
      // NOTE: every always_comb output gets a default before any branch,
      // so no path leaves a value unassigned and no latch is inferred.
      elig    = '0;
      add_req = '0;
      shf_req = '0;
      inv_req = '0;
      for (int p = 0; p < 4; p++) begin
         elig[p]    = (port_cmd[p] != CMD_IDLE) && !bitmap_q[p][port_tag[p]];
         add_req[p] = elig[p] &&
                      ((port_cmd[p] == CMD_ADD_A) || (port_cmd[p] == CMD_ADD_B));
         shf_req[p] = elig[p] &&
                      ((port_cmd[p] == CMD_SHF_A) || (port_cmd[p] == CMD_SHF_B));
         // Anything non-idle that is neither adder nor shifter is invalid.
         inv_req[p] = elig[p] && !add_req[p] && !shf_req[p];
      end
   end

   // ------------------------------------------------------------------------
   // Arbitration. The classes are disjoint, so a port can win at most one
   // channel in a cycle without any cross-channel masking.
   // ------------------------------------------------------------------------
   logic [2:0] add_pick;
   logic [2:0] shf_pick;
   logic [2:0] inv_pick;
   logic       add_gnt;
   logic       shf_gnt;
   logic       inv_gnt;
   logic [1:0] add_sel;
   logic [1:0] shf_sel;
   logic [1:0] inv_sel;

   assign add_pick = rr_pick(add_req, add_ptr_q);
   assign shf_pick = rr_pick(shf_req, shf_ptr_q);
   assign inv_pick = rr_pick(inv_req, 2'd0);

   // While reset is high, no grant may reach the outputs or the state.
   assign add_gnt = add_pick[2] && !reset;
   assign shf_gnt = shf_pick[2] && !reset;
   assign inv_gnt = inv_pick[2] && !reset;
   assign add_sel = add_pick[1:0];
   assign shf_sel = shf_pick[1:0];
   assign inv_sel = inv_pick[1:0];

   // ------------------------------------------------------------------------
   // Issue outputs. Fields are zero whenever their vld is low.
   // ------------------------------------------------------------------------
   always_comb begin : drive_out
      req_ack   = '0;
      add_vld   = 1'b0;
      add_cmd   = '0;
      add_port  = '0;
      add_tag   = '0;
      shf_vld   = 1'b0;
      shf_cmd   = '0;
      shf_port  = '0;
      shf_tag   = '0;
      inv_vld   = 1'b0;
      inv_port  = '0;
      inv_tag   = '0;
      // The error register may hold its old value until the first reset
      // edge, so the output is masked while reset is high.
      sched_err = err_q && !reset;

      if (add_gnt) begin
         add_vld          = 1'b1;
         add_cmd          = port_cmd[add_sel];
         add_port         = add_sel;
         add_tag          = port_tag[add_sel];
         req_ack[add_sel] = 1'b1;
      end
      if (shf_gnt) begin
         shf_vld          = 1'b1;
         shf_cmd          = port_cmd[shf_sel];
         shf_port         = shf_sel;
         shf_tag          = port_tag[shf_sel];
         req_ack[shf_sel] = 1'b1;
      end
      if (inv_gnt) begin
         inv_vld          = 1'b1;
         inv_port         = inv_sel;
         inv_tag          = port_tag[inv_sel];
         req_ack[inv_sel] = 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Next state
   // ------------------------------------------------------------------------
   always_comb begin : next_state
      bitmap_d  = bitmap_q;
      add_ptr_d = add_ptr_q;
      shf_ptr_d = shf_ptr_q;
      err_d     = err_q;

      // Grants mark their (port, tag) pair in flight. The pointer moves past
      // the winner, so that port has the lowest priority next time.
      if (add_gnt) begin
         bitmap_d[add_sel][port_tag[add_sel]] = 1'b1;
         add_ptr_d = add_sel + 2'd1;
      end
      if (shf_gnt) begin
         bitmap_d[shf_sel][port_tag[shf_sel]] = 1'b1;
         shf_ptr_d = shf_sel + 2'd1;
      end
      if (inv_gnt) begin
         bitmap_d[inv_sel][port_tag[inv_sel]] = 1'b1;
      end

      // Retires are applied after grants, so a clear of the same bit in the
      // same cycle wins. A retire is judged against the registered bitmap:
      // retiring a tag not in flight at the start of the cycle is an error.
      for (int p = 0; p < 4; p++) begin
         if (done_vld[p]) begin
            if (!bitmap_q[p][port_done_tag[p]]) begin
               err_d = 1'b1;
            end
            bitmap_d[p][port_done_tag[p]] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers. Reset wins over everything, so retires seen during
   // reset neither clear bits nor raise the error.
   // ------------------------------------------------------------------------
   always_ff @(posedge c_clk) begin
      if (reset) begin
         // NOTE: the 16-bit bitmap is control state, not a data memory. It
         // must start clean because a stale bit would block a port forever.
         bitmap_q  <= '0;
         add_ptr_q <= 2'd0;
         shf_ptr_q <= 2'd0;
         err_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register update from
         // the same pre-edge values, regardless of statement order.
         bitmap_q  <= bitmap_d;
         add_ptr_q <= add_ptr_d;
         shf_ptr_q <= shf_ptr_d;
         err_q     <= err_d;
      end
   end

endmodule

// File: tb/tb_calc2_sched.sv
// ---------------------------------------------------------------------------
// tb_calc2_sched -- self-checking bench for calc2_sched
//
// A behavioural reference model holds the outstanding (port, tag) set, the
// two round-robin pointers and the error flag. Each cycle it predicts the
// channel issues from the current requests. Directed scenarios cover the
// named behaviours. They are followed by a randomized phase in which
// requesters obey the hold-until-ack handshake and retires are drawn from
// the modelled in-flight set.
// ---------------------------------------------------------------------------
module tb_calc2_sched;

   logic        c_clk = 1'b0;
   logic        reset;
   logic [15:0] req_cmd_in;
   logic [7:0]  req_tag_in;
   logic [3:0]  req_ack;
   logic        add_vld;
   logic [3:0]  add_cmd;
   logic [1:0]  add_port;
   logic [1:0]  add_tag;
   logic        shf_vld;
   logic [3:0]  shf_cmd;
   logic [1:0]  shf_port;
   logic [1:0]  shf_tag;
   logic        inv_vld;
   logic [1:0]  inv_port;
   logic [1:0]  inv_tag;
   logic [3:0]  done_vld;
   logic [7:0]  done_tag;
   logic        sched_err;

   always #5 c_clk = ~c_clk;

   calc2_sched dut (
      .c_clk      (c_clk),
      .reset      (reset),
      .req_cmd_in (req_cmd_in),
      .req_tag_in (req_tag_in),
      .req_ack    (req_ack),
      .add_vld    (add_vld),
      .add_cmd    (add_cmd),
      .add_port   (add_port),
      .add_tag    (add_tag),
      .shf_vld    (shf_vld),
      .shf_cmd    (shf_cmd),
      .shf_port   (shf_port),
      .shf_tag    (shf_tag),
      .inv_vld    (inv_vld),
      .inv_port   (inv_port),
      .inv_tag    (inv_tag),
      .done_vld   (done_vld),
      .done_tag   (done_tag),
      .sched_err  (sched_err)
   );

   typedef struct packed {
      logic [3:0] ack;
      logic       add_vld;
      logic [3:0] add_cmd;
      logic [1:0] add_port;
      logic [1:0] add_tag;
      logic       shf_vld;
      logic [3:0] shf_cmd;
      logic [1:0] shf_port;
      logic [1:0] shf_tag;
      logic       inv_vld;
      logic [1:0] inv_port;
      logic [1:0] inv_tag;
      logic       err;
   } exp_t;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   bit   in_flight [4][4];
   int   add_ptr_m;
   int   shf_ptr_m;
   bit   err_m;
   exp_t exp_cur;

   // Bench-side stimulus (port index 0..3 = port 1..4)
   logic [3:0] cmd_r [4];
   logic [1:0] tag_r [4];
   logic [3:0] dv_r;
   logic [1:0] dt_r  [4];

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic bit is_add(input logic [3:0] c);
      return (c == 4'd1) || (c == 4'd2);
   endfunction

   function automatic bit is_shf(input logic [3:0] c);
      return (c == 4'd5) || (c == 4'd6);
   endfunction

   // Predict the outputs for the current requests from the model state.
   function automatic exp_t predict();
      exp_t e;
      bit   el [4];
      int   p;
      e = '0;
      if (reset) return e;
      for (int q = 0; q < 4; q++)
         el[q] = (cmd_r[q] != 4'd0) && !in_flight[q][tag_r[q]];
      for (int k = 0; k < 4; k++) begin
         p = (add_ptr_m + k) % 4;
         if (!e.add_vld && el[p] && is_add(cmd_r[p])) begin
            e.add_vld  = 1'b1;
            e.add_cmd  = cmd_r[p];
            e.add_port = 2'(p);
            e.add_tag  = tag_r[p];
            e.ack[p]   = 1'b1;
         end
      end
      for (int k = 0; k < 4; k++) begin
         p = (shf_ptr_m + k) % 4;
         if (!e.shf_vld && el[p] && is_shf(cmd_r[p])) begin
            e.shf_vld  = 1'b1;
            e.shf_cmd  = cmd_r[p];
            e.shf_port = 2'(p);
            e.shf_tag  = tag_r[p];
            e.ack[p]   = 1'b1;
         end
      end
      for (int q = 0; q < 4; q++) begin
         if (!e.inv_vld && el[q] && !is_add(cmd_r[q]) && !is_shf(cmd_r[q])) begin
            e.inv_vld  = 1'b1;
            e.inv_port = 2'(q);
            e.inv_tag  = tag_r[q];
            e.ack[q]   = 1'b1;
         end
      end
      e.err = err_m;
      return e;
   endfunction

   task automatic apply();
      for (int p = 0; p < 4; p++) begin
         req_cmd_in[4*p +: 4] = cmd_r[p];
         req_tag_in[2*p +: 2] = tag_r[p];
         done_tag[2*p +: 2]   = dt_r[p];
      end
      done_vld = dv_r;
   endtask

   task automatic idle();
      for (int p = 0; p < 4; p++) begin
         cmd_r[p] = 4'd0;
         tag_r[p] = 2'd0;
         dt_r[p]  = 2'd0;
      end
      dv_r = 4'd0;
   endtask

   // Drive the stimulus, then compare every output at the falling edge.
   task automatic settle(input string nm);
      apply();
      @(negedge c_clk);
      exp_cur = predict();
      check({nm, ":ack"}, 32'(req_ack), 32'(exp_cur.ack));
      check({nm, ":add"}, 32'({add_vld, add_cmd, add_port, add_tag}),
            32'({exp_cur.add_vld, exp_cur.add_cmd, exp_cur.add_port, exp_cur.add_tag}));
      check({nm, ":shf"}, 32'({shf_vld, shf_cmd, shf_port, shf_tag}),
            32'({exp_cur.shf_vld, exp_cur.shf_cmd, exp_cur.shf_port, exp_cur.shf_tag}));
      check({nm, ":inv"}, 32'({inv_vld, inv_port, inv_tag}),
            32'({exp_cur.inv_vld, exp_cur.inv_port, exp_cur.inv_tag}));
      check({nm, ":err"}, 32'(sched_err), 32'(exp_cur.err));
   endtask

   // Rising edge: update the model, then move off the edge.
   task automatic advance();
      @(posedge c_clk);
      if (reset) begin
         for (int p = 0; p < 4; p++)
            for (int t = 0; t < 4; t++) in_flight[p][t] = 1'b0;
         add_ptr_m = 0;
         shf_ptr_m = 0;
         err_m     = 1'b0;
      end else begin
         for (int p = 0; p < 4; p++)
            if (dv_r[p] && !in_flight[p][dt_r[p]]) err_m = 1'b1;
         if (exp_cur.add_vld) add_ptr_m = (int'(exp_cur.add_port) + 1) % 4;
         if (exp_cur.shf_vld) shf_ptr_m = (int'(exp_cur.shf_port) + 1) % 4;
         for (int p = 0; p < 4; p++)
            if (exp_cur.ack[p]) in_flight[p][tag_r[p]] = 1'b1;
         for (int p = 0; p < 4; p++)
            if (dv_r[p]) in_flight[p][dt_r[p]] = 1'b0;
      end
      #1;
   endtask

   task automatic step(input string nm);
      settle(nm);
      advance();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle();
      step("rst");
      reset = 1'b0;
   endtask

   function automatic logic [3:0] pick_cmd();
      logic [3:0] tbl [10];
      tbl = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd1, 4'd2, 4'd5, 4'd6, 4'd3, 4'd12};
      return tbl[$urandom_range(0, 9)];
   endfunction

   initial begin
      logic [3:0] last_ack;
      logic [1:0] t;
      add_ptr_m = 0;
      shf_ptr_m = 0;
      err_m     = 1'b0;

      // Reset with busy inputs and retires: everything must stay quiet.
      reset = 1'b1;
      idle();
      for (int p = 0; p < 4; p++) begin
         cmd_r[p] = 4'(p + 1);
         tag_r[p] = 2'(p);
         dt_r[p]  = 2'(3 - p);
      end
      dv_r = 4'hF;
      settle("rst_busy");
      check("rst_ack_zero", 32'(req_ack), 32'd0);
      check("rst_vld_zero", 32'({add_vld, shf_vld, inv_vld}), 32'd0);
      check("rst_err_zero", 32'(sched_err), 32'd0);
      advance();
      step("rst_busy2");
      reset = 1'b0;
      idle();
      settle("post_rst");
      check("post_rst_err", 32'(sched_err), 32'd0);
      advance();

      // Adder and shifter grant in the same cycle (ack bit0 = port 1).
      cmd_r[0] = 4'd1; tag_r[0] = 2'd0;
      cmd_r[2] = 4'd5; tag_r[2] = 2'd2;
      settle("dual");
      check("dual_add", 32'({add_vld, add_port}), 32'({1'b1, 2'd0}));
      check("dual_shf", 32'({shf_vld, shf_port}), 32'({1'b1, 2'd2}));
      check("dual_ack", 32'(req_ack), 32'b0101);
      advance();
      idle();
      dv_r[0] = 1'b1; dt_r[0] = 2'd0;
      dv_r[2] = 1'b1; dt_r[2] = 2'd2;
      step("dual_done");

      // Invalid channel: lowest port first, the other on the next cycle.
      idle();
      cmd_r[0] = 4'd9; cmd_r[2] = 4'd9;
      settle("inv1");
      check("inv_first", 32'({inv_vld, inv_port}), 32'({1'b1, 2'd0}));
      advance();
      cmd_r[0] = 4'd0;
      settle("inv2");
      check("inv_second", 32'({inv_vld, inv_port}), 32'({1'b1, 2'd2}));
      advance();
      idle();
      dv_r[0] = 1'b1; dv_r[2] = 1'b1;
      step("inv_done");

      // Duplicate tag is held until its retire has been registered.
      idle();
      cmd_r[1] = 4'd1; tag_r[1] = 2'd1;
      settle("dup1");
      check("dup_first_ack", 32'(req_ack), 32'b0010);
      advance();
      settle("dup2");
      check("dup_held", 32'(req_ack), 32'b0000);
      advance();
      dv_r[1] = 1'b1; dt_r[1] = 2'd1;
      settle("dup3");
      check("dup_held_done", 32'(req_ack), 32'b0000);
      advance();
      dv_r[1] = 1'b0;
      settle("dup4");
      check("dup_acked", 32'(req_ack), 32'b0010);
      advance();
      idle();
      dv_r[1] = 1'b1; dt_r[1] = 2'd1;
      step("dup_clean");

      // Port 4 fills all tags, then stalls until tag 3 retires.
      idle();
      for (int i = 0; i < 4; i++) begin
         cmd_r[3] = 4'd6; tag_r[3] = 2'(i);
         settle("fill");
         check("fill_ack", 32'(req_ack), 32'b1000);
         advance();
      end
      tag_r[3] = 2'd3;
      settle("full");
      check("full_held", 32'(req_ack), 32'b0000);
      advance();
      dv_r[3] = 1'b1; dt_r[3] = 2'd3;
      settle("full_done");
      check("full_held_done", 32'(req_ack), 32'b0000);
      advance();
      dv_r[3] = 1'b0;
      settle("full_go");
      check("full_ack", 32'(req_ack), 32'b1000);
      check("full_shf", 32'({shf_vld, shf_tag}), 32'({1'b1, 2'd3}));
      advance();
      idle();
      for (int i = 0; i < 4; i++) begin
         dv_r[3] = 1'b1; dt_r[3] = 2'(i);
         step("full_clean");
      end

      // Round-robin over four adder requesters from a fresh pointer.
      do_reset();
      for (int p = 0; p < 4; p++) begin
         cmd_r[p] = 4'd2; tag_r[p] = 2'd0;
      end
      for (int i = 0; i < 5; i++) begin
         settle("rr");
         check("rr_port", 32'({add_vld, add_port}), 32'({1'b1, 2'(i % 4)}));
         check("rr_ack", 32'(req_ack), 32'(4'b0001 << (i % 4)));
         advance();
         tag_r[i % 4] = tag_r[i % 4] + 2'd1;
      end

      // Grant and retire of the same pair in one cycle: the clear wins.
      do_reset();
      cmd_r[0] = 4'd1; tag_r[0] = 2'd0;
      dv_r[0] = 1'b1; dt_r[0] = 2'd0;
      settle("same1");
      check("same_ack1", 32'(req_ack), 32'b0001);
      advance();
      dv_r[0] = 1'b0;
      settle("same2");
      check("same_ack2", 32'(req_ack), 32'b0001);
      advance();

      // Mid-operation reset drops outstanding tags; retires are ignored.
      do_reset();
      cmd_r[0] = 4'd1; tag_r[0] = 2'd3;
      step("mid_grant");
      reset = 1'b1;
      idle();
      dv_r[1] = 1'b1;
      step("mid_rst");
      reset = 1'b0;
      idle();
      cmd_r[0] = 4'd1; tag_r[0] = 2'd3;
      settle("mid_after");
      check("mid_reack", 32'(req_ack), 32'b0001);
      check("mid_err", 32'(sched_err), 32'd0);
      advance();

      // Spurious retire sets a sticky error that only reset clears.
      do_reset();
      dv_r[0] = 1'b1; dt_r[0] = 2'd2;
      settle("err0");
      check("err_before", 32'(sched_err), 32'd0);
      advance();
      idle();
      for (int i = 0; i < 3; i++) begin
         settle("err_hold");
         check("err_sticky", 32'(sched_err), 32'd1);
         advance();
      end
      reset = 1'b1;
      settle("err_rst");
      check("err_in_rst", 32'(sched_err), 32'd0);
      advance();
      reset = 1'b0;
      settle("err_clr");
      check("err_cleared", 32'(sched_err), 32'd0);
      advance();

      // Randomized traffic against the model.
      do_reset();
      last_ack = 4'd0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
         reset = ($urandom_range(0, 299) == 0);
         for (int p = 0; p < 4; p++) begin
            if (cmd_r[p] == 4'd0 || last_ack[p]) begin
               if ($urandom_range(0, 3) == 0) cmd_r[p] = 4'd0;
               else                           cmd_r[p] = pick_cmd();
               tag_r[p] = 2'($urandom_range(0, 3));
            end
            dv_r[p] = 1'b0;
            t = 2'($urandom_range(0, 3));
            dt_r[p] = t;
            if ($urandom_range(0, 2) == 0 && in_flight[p][t]) dv_r[p] = 1'b1;
         end
         step("rnd");
         last_ack = exp_cur.ack;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
